// File: rtl/exu_issue.sv
// Issue-side controller for the execute unit: accepts one decoded instruction,
// pulses it into the EXU, waits for completion (with watchdog) and hands the result to writeback.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`endif
`ifndef BRSEL_WIDTH
`define BRSEL_WIDTH 3
`endif

module exu_issue #(
    parameter int TIMEOUT = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    // decode side
    input  logic                    id_valid,
    output logic                    id_ready,
    input  logic [63:0]             id_A,
    input  logic [63:0]             id_B,
    input  logic [63:0]             id_rs1,
    input  logic [63:0]             id_rs2,
    input  logic [63:0]             id_pc,
    input  logic [63:0]             id_sext,
    input  logic [`ALUOP_WIDTH-1:0] id_ALUop,
    input  logic [`BRSEL_WIDTH-1:0] id_BRsel,
    input  logic [2:0]              id_rsel,
    input  logic [4:0]              id_rd,
    input  logic                    id_wen,
    input  logic                    flush,
    // execute unit side
    output logic                    exu_valid,
    output logic [63:0]             A,
    output logic [63:0]             B,
    output logic [63:0]             rs1,
    output logic [63:0]             rs2,
    output logic [63:0]             pc,
    output logic [63:0]             sext_num,
    output logic [`ALUOP_WIDTH-1:0] ALUop,
    output logic [`BRSEL_WIDTH-1:0] BRsel,
    input  logic                    exu_finish,
    input  logic [63:0]             alu_out,
    input  logic [63:0]             br_out,
    input  logic [63:0]             div_out,
    input  logic [63:0]             rem_out,
    input  logic [63:0]             mul_out,
    input  logic                    redirect_valid_out,
    // writeback side
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [63:0]             wb_data,
    output logic [4:0]              wb_rd,
    output logic                    wb_wen,
    output logic                    wb_redirect,
    output logic [63:0]             wb_target,
    output logic                    timeout_err
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [63:0]             a;
        logic [63:0]             b;
        logic [63:0]             rs1;
        logic [63:0]             rs2;
        logic [63:0]             pc;
        logic [63:0]             sext;
        logic [`ALUOP_WIDTH-1:0] aluop;
        logic [`BRSEL_WIDTH-1:0] brsel;
        logic [2:0]              rsel;
        logic [4:0]              rd;
        logic                    wen;
    } op_t;

    typedef struct packed {
        logic [63:0] data;
        logic [63:0] target;
        logic [4:0]  rd;
        logic        wen;
        logic        redirect;
    } wb_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d;
    op_t           op_q, op_d;
    wb_t           wb_q, wb_d;
    logic          wb_valid_q, wb_valid_d;
    logic          timeout_err_q, timeout_err_d;
    logic [63:0]   res;

    // rsel codes 5..7 fall back to the ALU result
    always_comb begin
        case (op_q.rsel)
            3'd1:    res = br_out;
            3'd2:    res = div_out;
            3'd3:    res = rem_out;
            3'd4:    res = mul_out;
            default: res = alu_out;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        kill_d        = kill_q;
        op_d          = op_q;
        wb_d          = wb_q;
        wb_valid_d    = wb_valid_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (id_valid && !flush) begin
                    op_d.a     = id_A;
                    op_d.b     = id_B;
                    op_d.rs1   = id_rs1;
                    op_d.rs2   = id_rs2;
                    op_d.pc    = id_pc;
                    op_d.sext  = id_sext;
                    op_d.aluop = id_ALUop;
                    op_d.brsel = id_BRsel;
                    op_d.rsel  = id_rsel;
                    op_d.rd    = id_rd;
                    op_d.wen   = id_wen;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                kill_d  = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // a flushed div/mul still has to drain before the unit is reusable
                if (flush) kill_d = 1'b1;
                if (exu_finish) begin
                    if (kill_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        wb_d.data     = res;
                        wb_d.target   = br_out;
                        wb_d.rd       = op_q.rd;
                        wb_d.wen      = op_q.wen;
                        wb_d.redirect = redirect_valid_out;
                        wb_valid_d    = 1'b1;
                        state_d       = S_RESP;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_RESP: begin
                if (wb_ready || flush) begin
                    wb_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            kill_q        <= 1'b0;
            op_q          <= '0;
            wb_q          <= '0;
            wb_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            kill_q        <= kill_d;
            op_q          <= op_d;
            wb_q          <= wb_d;
            wb_valid_q    <= wb_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign id_ready    = (state_q == S_IDLE);
    assign exu_valid   = (state_q == S_ISSUE);
    assign A           = op_q.a;
    assign B           = op_q.b;
    assign rs1         = op_q.rs1;
    assign rs2         = op_q.rs2;
    assign pc          = op_q.pc;
    assign sext_num    = op_q.sext;
    assign ALUop       = op_q.aluop;
    assign BRsel       = op_q.brsel;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_q.data;
    assign wb_rd       = wb_q.rd;
    assign wb_wen      = wb_q.wen;
    assign wb_redirect = wb_q.redirect;
    assign wb_target   = wb_q.target;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_exu_issue.sv
// Self-checking bench for exu_issue: vector table plus directed corner sequences,
// writeback results checked through a scoreboard queue.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`endif
`ifndef BRSEL_WIDTH
`define BRSEL_WIDTH 3
`endif

module tb_exu_issue;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_wen, flush, exu_finish, redirect_valid_out, wb_ready;
    logic [63:0] id_A, id_B, id_rs1, id_rs2, id_pc, id_sext;
    logic [`ALUOP_WIDTH-1:0] id_ALUop;
    logic [`BRSEL_WIDTH-1:0] id_BRsel;
    logic [2:0] id_rsel;
    logic [4:0] id_rd;
    logic [63:0] alu_out, br_out, div_out, rem_out, mul_out;

    logic id_ready, exu_valid, wb_valid, wb_wen, wb_redirect, timeout_err;
    logic [63:0] A, B, rs1, rs2, pc, sext_num, wb_data, wb_target;
    logic [`ALUOP_WIDTH-1:0] ALUop;
    logic [`BRSEL_WIDTH-1:0] BRsel;
    logic [4:0] wb_rd;

    // second instance with a short watchdog
    logic wd_id_ready, wd_exu_valid, wd_wb_valid, wd_wb_wen, wd_wb_redirect, wd_timeout_err;
    logic [63:0] wd_A, wd_B, wd_rs1, wd_rs2, wd_pc, wd_sext_num, wd_wb_data, wd_wb_target;
    logic [`ALUOP_WIDTH-1:0] wd_ALUop;
    logic [`BRSEL_WIDTH-1:0] wd_BRsel;
    logic [4:0] wd_wb_rd;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        redir;
        logic [63:0] tgt;
    } wb_t;
    wb_t sb[$];

    typedef struct {
        logic [2:0]  rsel;
        logic [4:0]  rd;
        logic        wen;
        int          lat;
        int          hold;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    // EXU model: results are simple functions of the latched operands
    assign alu_out = A + B;
    assign br_out  = A ^ 64'hB0;
    assign div_out = A >> 1;
    assign rem_out = A & 64'h7;
    assign mul_out = A * B;

    exu_issue #(.TIMEOUT(128)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_A(id_A), .id_B(id_B), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_pc(id_pc), .id_sext(id_sext),
        .id_ALUop(id_ALUop), .id_BRsel(id_BRsel), .id_rsel(id_rsel), .id_rd(id_rd), .id_wen(id_wen),
        .flush(flush), .exu_valid(exu_valid), .A(A), .B(B), .rs1(rs1), .rs2(rs2), .pc(pc),
        .sext_num(sext_num), .ALUop(ALUop), .BRsel(BRsel), .exu_finish(exu_finish),
        .alu_out(alu_out), .br_out(br_out), .div_out(div_out), .rem_out(rem_out), .mul_out(mul_out),
        .redirect_valid_out(redirect_valid_out), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_redirect(wb_redirect),
        .wb_target(wb_target), .timeout_err(timeout_err)
    );

    exu_issue #(.TIMEOUT(8)) u_wd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(wd_id_ready),
        .id_A(id_A), .id_B(id_B), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_pc(id_pc), .id_sext(id_sext),
        .id_ALUop(id_ALUop), .id_BRsel(id_BRsel), .id_rsel(id_rsel), .id_rd(id_rd), .id_wen(id_wen),
        .flush(flush), .exu_valid(wd_exu_valid), .A(wd_A), .B(wd_B), .rs1(wd_rs1), .rs2(wd_rs2),
        .pc(wd_pc), .sext_num(wd_sext_num), .ALUop(wd_ALUop), .BRsel(wd_BRsel), .exu_finish(exu_finish),
        .alu_out(alu_out), .br_out(br_out), .div_out(div_out), .rem_out(rem_out), .mul_out(mul_out),
        .redirect_valid_out(redirect_valid_out), .wb_valid(wd_wb_valid), .wb_ready(wb_ready),
        .wb_data(wd_wb_data), .wb_rd(wd_wb_rd), .wb_wen(wd_wb_wen), .wb_redirect(wd_wb_redirect),
        .wb_target(wd_wb_target), .timeout_err(wd_timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && id_ready !== 1'b1; i++) tick();
        check("wait_ready", id_ready, 1);
    endtask

    // drives one instruction; returns during the first WAIT cycle
    task automatic accept(input logic [2:0] rsel, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic wen);
        wait_ready();
        id_valid = 1'b1; id_rsel = rsel; id_A = a; id_B = b; id_rs1 = a ^ 64'h5555;
        id_rs2 = b; id_pc = 64'h1000; id_sext = 64'h20; id_rd = rd; id_wen = wen;
        id_ALUop = `ALUOP_WIDTH'(rsel + 3'd1); id_BRsel = `BRSEL_WIDTH'(2);
        tick();
        id_valid = 1'b0;
        check("issue_pulse", exu_valid, 1);
        check("busy_issue", id_ready, 0);
        check("op_A", A, a);
        check("op_ALUop", 64'(ALUop), 64'(`ALUOP_WIDTH'(rsel + 3'd1)));
        tick();
        check("pulse_one_cycle", exu_valid, 0);
    endtask

    task automatic run(input logic [2:0] rsel, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic wen, input logic redir,
                       input int lat, input int hold, input logic [63:0] exp);
        wb_t e;
        wb_t got;
        redirect_valid_out = redir;
        e.data = exp; e.rd = rd; e.wen = wen; e.redir = redir; e.tgt = a ^ 64'hB0;
        sb.push_back(e);
        accept(rsel, a, b, rd, wen);
        for (int i = 1; i <= lat; i++) begin
            if (i == lat) exu_finish = 1'b1;
            check("hold_A", A, a);
            check("hold_rs1", rs1, a ^ 64'h5555);
            check("no_wb_in_wait", wb_valid, 0);
            tick();
        end
        exu_finish = 1'b0;
        check("wb_valid_rise", wb_valid, 1);
        for (int h = 0; h < hold; h++) begin
            check("bp_valid", wb_valid, 1);
            check("bp_data", wb_data, exp);
            check("bp_busy", id_ready, 0);
            tick();
        end
        wb_ready = 1'b1;
        check("resp_busy", id_ready, 0);
        check("hs_valid", wb_valid, 1);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            check("wb_data", wb_data, got.data);
            check("wb_rd", 64'(wb_rd), 64'(got.rd));
            check("wb_wen", 64'(wb_wen), 64'(got.wen));
            check("wb_redirect", 64'(wb_redirect), 64'(got.redir));
            check("wb_target", wb_target, got.tgt);
        end
        tick();
        wb_ready = 1'b0;
        redirect_valid_out = 1'b0;
        check("wb_valid_drop", wb_valid, 0);
        check("idle_after_hs", id_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{3'd0, 5'd1,  1'b1, 1, 0, 64'h67};
        vecs[1] = '{3'd1, 5'd2,  1'b0, 2, 0, 64'hD4};
        vecs[2] = '{3'd2, 5'd3,  1'b1, 3, 1, 64'h32};
        vecs[3] = '{3'd3, 5'd4,  1'b1, 1, 0, 64'h4};
        vecs[4] = '{3'd4, 5'd5,  1'b1, 2, 2, 64'h12C};
        vecs[5] = '{3'd5, 5'd6,  1'b1, 1, 0, 64'h67};
        vecs[6] = '{3'd6, 5'd7,  1'b0, 1, 0, 64'h67};
        vecs[7] = '{3'd7, 5'd31, 1'b1, 3, 0, 64'h67};

        rst = 1'b1; id_valid = 0; id_wen = 0; flush = 0; exu_finish = 0;
        redirect_valid_out = 0; wb_ready = 0; id_A = 0; id_B = 0; id_rs1 = 0; id_rs2 = 0;
        id_pc = 0; id_sext = 0; id_ALUop = 0; id_BRsel = 0; id_rsel = 0; id_rd = 0;
        #22;
        rst = 1'b0;
        tick();
        check("rst_id_ready", id_ready, 1);
        check("rst_exu_valid", exu_valid, 0);
        check("rst_wb_ctl", {59'd0, wb_valid, wb_redirect, wb_wen, timeout_err, 1'b0}, 0);
        check("rst_ops", A | B | rs1 | rs2 | pc | sext_num, 0);
        check("rst_wb64", wb_data | wb_target, 0);
        check("rst_ctl", 64'({ALUop, BRsel, wb_rd}), 0);

        for (int i = 0; i < 8; i++)
            run(vecs[i].rsel, 64'd100, 64'd3, vecs[i].rd, vecs[i].wen, 1'b0,
                vecs[i].lat, vecs[i].hold, vecs[i].exp);

        // flush while idle: nothing accepted, operands untouched
        id_valid = 1'b1; flush = 1'b1; id_A = 64'hDEAD;
        tick();
        id_valid = 1'b0; flush = 1'b0;
        check("idle_flush_no_issue", exu_valid, 0);
        check("idle_flush_ready", id_ready, 1);
        check("idle_flush_A", A, 64'd100);

        run(3'd0, 64'd5, 64'd7, 5'd10, 1'b1, 1'b0, 2, 0, 64'd12);
        run(3'd4, 64'd6, 64'd7, 5'd11, 1'b1, 1'b0, 1, 5, 64'd42);
        run(3'd1, 64'h800000A0, 64'd0, 5'd12, 1'b0, 1'b1, 1, 0, 64'h80000010);

        // flush in WAIT: result discarded, unit still waits for finish
        accept(3'd0, 64'd1, 64'd2, 5'd9, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            flush = (i == 3);
            exu_finish = (i == 10);
            check("flush_no_wb", wb_valid, 0);
            if (i > 1 && i < 10) check("flush_still_busy", id_ready, 0);
            tick();
        end
        flush = 1'b0; exu_finish = 1'b0;
        check("flush_no_wb_after", wb_valid, 0);
        check("flush_ready_after", id_ready, 1);

        // flush in RESP with wb_ready low
        accept(3'd0, 64'd3, 64'd4, 5'd8, 1'b1);
        exu_finish = 1'b1;
        tick();
        exu_finish = 1'b0;
        check("resp_flush_pre", wb_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("resp_flush_drop", wb_valid, 0);
        check("resp_flush_idle", id_ready, 1);

        run(3'd3, 64'h13, 64'd5, 5'd13, 1'b1, 1'b0, 66, 0, 64'h3);
        check("div_no_timeout", timeout_err, 0);

        // watchdog on the TIMEOUT=8 instance
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        tick();
        check("wd_rst", {wd_id_ready, wd_exu_valid, wd_wb_valid, wd_wb_wen, wd_wb_redirect,
                         wd_timeout_err, wd_ALUop, wd_BRsel, wd_wb_rd} == 0 ? 64'd1 : 64'd0, 0);
        check("wd_rst_64", wd_A | wd_B | wd_rs1 | wd_rs2 | wd_pc | wd_sext_num | wd_wb_data | wd_wb_target, 0);
        check("wd_rst_ready", wd_id_ready, 1);
        accept(3'd0, 64'd9, 64'd9, 5'd2, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            check("wd_no_err_yet", wd_timeout_err, 0);
            tick();
        end
        check("wd_timeout_set", wd_timeout_err, 1);
        check("wd_idle_after_to", wd_id_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wd_timeout_sticky", wd_timeout_err, 1);
        end
        exu_finish = 1'b1;
        tick();
        exu_finish = 1'b0;
        check("wd_finish_ignored", wd_wb_valid, 0);
        check("dut_finish_taken", wb_valid, 1);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        run(3'd2, 64'd40, 64'd1, 5'd3, 1'b1, 1'b0, 1, 0, 64'h14);
        check("wd_next_accepted", wd_wb_data, 64'h14);
        check("wd_err_still_set", wd_timeout_err, 1);

        // async reset during ISSUE
        wait_ready();
        id_valid = 1'b1; id_rsel = 3'd0;
        tick();
        id_valid = 1'b0;
        check("pre_rst_issue", exu_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_exu_valid", exu_valid, 0);
        check("rst_async_wd_err", wd_timeout_err, 0);
        #2 rst = 1'b0;
        tick();
        check("rst_issue_idle", id_ready, 1);

        // async reset during WAIT
        accept(3'd0, 64'd2, 64'd2, 5'd4, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_wait_exu_valid", exu_valid, 0);
        check("rst_wait_wb_valid", wb_valid, 0);
        check("rst_wait_idle", id_ready, 1);
        #2 rst = 1'b0;
        tick();

        // async reset during RESP
        accept(3'd4, 64'd2, 64'd3, 5'd5, 1'b1);
        exu_finish = 1'b1;
        tick();
        exu_finish = 1'b0;
        check("pre_rst_resp", wb_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_wb_valid", wb_valid, 0);
        check("rst_async_wb_data", wb_data, 0);
        #2 rst = 1'b0;
        tick();
        check("rst_resp_idle", id_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
